// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================
// spi_slave_pkg : shared types and constants for the SPI slave
// Revision: 1.0
// ============================================================
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    RD_WAIT   = 3'd5,
    RD_SEND   = 3'd6,
    HOLD      = 3'd7
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int DEF_FRAME_W = 10;
  localparam int DEF_TX_W    = 8;

endpackage
`default_nettype wire

// File: rtl/spi_slave_ctrl_if.sv
`default_nettype none
// ============================================================
// spi_slave_ctrl_if : SPI pins plus memory-side rx/tx handshake
// Revision: 1.0
// ============================================================
interface spi_slave_ctrl_if #(
  parameter int FRAME_W = spi_slave_pkg::DEF_FRAME_W,
  parameter int TX_W    = spi_slave_pkg::DEF_TX_W
);
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [TX_W-1:0]    tx_data;
  logic               tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================
// spi_bit_counter : per-frame bit counter, cleared when idle
// Revision: 1.0
// ============================================================
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             run_i,
  input  wire logic             clear_i,
  output logic      [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear_i || !run_i) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_ctrl.sv
`default_nettype none
// ============================================================
// spi_slave_ctrl : SPI slave frame sequencer (rx deserialise, tx readback)
// Revision: 1.0
// ============================================================
module spi_slave_ctrl
  import spi_slave_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int TX_W    = DEF_TX_W,
  parameter int CNT_W   = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  spi_slave_ctrl_if.slave bus
);

  state_t             state_q, state_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               miso_q, miso_d;
  logic [TX_W-2:0]    tx_q, tx_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic               cnt_run;
  logic [CNT_W-1:0]   cnt;

  assign cnt_run = (state_q == WRITE) || (state_q == READ_ADD) ||
                   (state_q == READ_DATA) || (state_q == RD_SEND);

  spi_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .run_i   (cnt_run),
    .clear_i (bus.SS_n),
    .count_o (cnt)
  );

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = miso_q;
    tx_d           = tx_q;
    rd_addr_seen_d = rd_addr_seen_q;

    // Deselect outside IDLE discards whatever frame is in flight.
    if (bus.SS_n && (state_q != IDLE)) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (!bus.SS_n) state_d = CHK_CMD;
        end
        CHK_CMD: begin
          if (!bus.MOSI)          state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                    state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          shift_d = {shift_q[FRAME_W-3:0], bus.MOSI};
          if (cnt == CNT_W'(FRAME_W - 1)) begin
            rx_data_d  = {shift_q, bus.MOSI};
            rx_valid_d = 1'b1;
            if (state_q == READ_DATA) begin
              rd_addr_seen_d = 1'b0;
              state_d        = RD_WAIT;
            end else begin
              if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
              state_d = HOLD;
            end
          end
        end
        RD_WAIT: begin
          if (bus.tx_valid) begin
            tx_d    = bus.tx_data[TX_W-2:0];
            miso_d  = bus.tx_data[TX_W-1];
            state_d = RD_SEND;
          end
        end
        RD_SEND: begin
          if (cnt == CNT_W'(TX_W - 1)) begin
            miso_d  = 1'b0;
            state_d = HOLD;
          end else begin
            miso_d = tx_q[TX_W-2];
            tx_d   = {tx_q[TX_W-3:0], 1'b0};
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      tx_q           <= '0;
      rd_addr_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      tx_q           <= tx_d;
      rd_addr_seen_q <= rd_addr_seen_d;
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_ctrl.sv
`default_nettype none
// ============================================================
// tb_spi_slave_ctrl : directed vector table plus corner-case sequences
// Revision: 1.0
// ============================================================
module tb_spi_slave_ctrl;
  import spi_slave_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_ctrl_if #(.FRAME_W(10), .TX_W(8)) bus ();

  spi_slave_ctrl #(.FRAME_W(10), .TX_W(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       ss;
    logic       mosi;
    logic       txv;
    logic [7:0] txd;
    logic       miso;
    logic       rxv;
    logic [9:0] rxd;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic [9:0] exp_rx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic ss, input logic mosi, input logic txv, input logic [7:0] txd);
    bus.SS_n     = ss;
    bus.MOSI     = mosi;
    bus.tx_valid = txv;
    bus.tx_data  = txd;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic ss, input logic mosi, input logic txv,
                              input logic [7:0] txd, input logic miso, input logic rxv,
                              input logic [9:0] rxd);
    tbl.push_back('{ss, mosi, txv, txd, miso, rxv, rxd});
  endfunction

  // One full frame E0..E11; noisy tx_valid on alternate payload bits when asked.
  function automatic void add_frame(input logic cmd, input logic [9:0] pl,
                                    input logic [9:0] prev, input logic noise);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, prev);
    add(1'b0, cmd,  1'b0, 8'h00, 1'b0, 1'b0, prev);
    for (int i = 9; i >= 0; i--)
      add(1'b0, pl[i], noise & i[0], 8'hFF, 1'b0, (i == 0), (i == 0) ? pl : prev);
  endfunction

  task automatic frame(input string tag, input logic cmd, input logic [9:0] pl,
                       input int nbits, input state_t exp_st);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk({tag, "_e0_state"}, 32'(dut.state_q), 32'(CHK_CMD));
    tick(1'b0, cmd, 1'b0, 8'h00);
    chk({tag, "_e1_state"}, 32'(dut.state_q), 32'(exp_st));
    for (int k = 0; k < nbits; k++) begin
      tick(1'b0, pl[9-k], 1'b0, 8'h00);
      if (k == 9) begin
        chk({tag, "_rxv"}, 32'(bus.rx_valid), 32'd1);
        chk({tag, "_rxd"}, 32'(bus.rx_data), 32'(pl));
        exp_rx = pl;
      end else begin
        chk($sformatf("%s_b%0d_rxv", tag, k), 32'(bus.rx_valid), 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] b;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;

    // ---------------- vector table ----------------
    add_frame(1'b0, 10'h0A5, 10'h000, 1'b1);
    add(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 10'h0A5);
    add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 10'h0A5);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h0A5);
    add_frame(1'b1, 10'h233, 10'h0A5, 1'b0);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h233);
    add_frame(1'b1, 10'h300, 10'h233, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 10'h300);
    b = 8'hC3;
    for (int i = 6; i >= 0; i--) add(1'b0, 1'b0, 1'b0, 8'h00, b[i], 1'b0, 10'h300);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h300);
    add(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 10'h300);
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h300);

    // ---------------- reset ----------------
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_out", {bus.MISO, bus.rx_valid, bus.rx_data}, 32'd0);
    chk("rst_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("idle_hold", 32'(dut.state_q), 32'(IDLE));

    foreach (tbl[i]) begin
      tick(tbl[i].ss, tbl[i].mosi, tbl[i].txv, tbl[i].txd);
      chk($sformatf("vec%0d", i), {bus.MISO, bus.rx_valid, bus.rx_data},
          {tbl[i].miso, tbl[i].rxv, tbl[i].rxd});
    end
    exp_rx = 10'h300;

    // ---------------- read wait ----------------
    frame("rwa", 1'b1, 10'h1C4, 10, READ_ADD);
    chk("rwa_seen", 32'(dut.rd_addr_seen_q), 32'd1);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    frame("rwd", 1'b1, 10'h3C4, 10, READ_DATA);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'h5A);
      chk($sformatf("rw_wait%0d", i), {bus.MISO, 3'(dut.state_q)}, {1'b0, 3'(RD_WAIT)});
    end
    tick(1'b0, 1'b0, 1'b1, 8'h5A);
    chk("rw_start", {bus.MISO, 3'(dut.state_q)}, {1'b0, 3'(RD_SEND)});
    b = 8'h5A;
    for (int i = 6; i >= 0; i--) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      chk($sformatf("rw_bit%0d", i), 32'(bus.MISO), 32'(b[i]));
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rw_end", {bus.MISO, 3'(dut.state_q)}, {1'b0, 3'(HOLD)});
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // ---------------- write abort after 6 bits ----------------
    frame("wab", 1'b0, 10'h3FF, 6, WRITE);
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    chk("wab_state", 32'(dut.state_q), 32'(IDLE));
    chk("wab_out", {bus.MISO, bus.rx_valid, bus.rx_data}, {1'b0, 1'b0, exp_rx});
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("wab_idle_rxv", 32'(bus.rx_valid), 32'd0);

    // ---------------- aborted READ_ADD, back-to-back restart ----------------
    frame("rab", 1'b1, 10'h155, 4, READ_ADD);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    chk("rab_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    frame("rab2", 1'b1, 10'h2AA, 10, READ_ADD);
    chk("rab2_seen", 32'(dut.rd_addr_seen_q), 32'd1);
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    // ---------------- abort on the final bit ----------------
    frame("e11", 1'b1, 10'h301, 9, READ_DATA);
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    chk("e11_out", {bus.rx_valid, bus.rx_data}, {1'b0, exp_rx});
    chk("e11_state", 32'(dut.state_q), 32'(IDLE));
    chk("e11_seen", 32'(dut.rd_addr_seen_q), 32'd1);

    // ---------------- reset during RD_SEND ----------------
    frame("rsd", 1'b1, 10'h311, 10, READ_DATA);
    tick(1'b0, 1'b0, 1'b1, 8'hC3);
    chk("rsd_b7", 32'(bus.MISO), 32'd1);
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rsd_b6", 32'(bus.MISO), 32'd1);
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rsd_state", 32'(dut.state_q), 32'(IDLE));
    chk("rsd_out", {bus.MISO, bus.rx_valid, bus.rx_data}, 32'd0);
    chk("rsd_seen", 32'(dut.rd_addr_seen_q), 32'd0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
